// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Constants are common to baud_rate_generator, uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_SAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency.
// No handshake; reset value is parameterised so idle-high lines stay high through reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (even parity when UART_RX_PARITY_EN is defined); data_valid 1 clock after stop-centre tick.
// Byte held until data_ack; a frame finishing while a byte is held is dropped and flagged as overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SAMPLE_RATE = UART_SAMPLE_RATE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  input  logic                 data_ack,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_t            state;
  logic                 rx_s;
  logic                 rx_prev;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 centre_hit;
  logic                 end_hit;
  logic                 par_bad;
  logic                 frame_ok;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign centre_hit = tick && (tick_cnt == CW'(SAMPLE_RATE / 2 - 1));
  assign end_hit    = tick && (tick_cnt == CW'(SAMPLE_RATE - 1));
  assign busy       = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ^{shift_reg, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  assign frame_ok = rx_s && !par_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rx_prev       <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      start_rx      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      rx_prev       <= rx_s;
      start_rx      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (data_ack && data_valid)
        data_valid <= 1'b0;
      if (tick)
        tick_cnt <= tick_cnt + CW'(1);

      case (state)
        IDLE: begin
          // Only a genuine high-to-low edge starts a frame; a held-low line never does.
          if (rx_prev && !rx_s) begin
            start_rx <= 1'b1;
            state    <= START;
            tick_cnt <= tick ? CW'(1) : '0;
          end
        end
        START: begin
          if (centre_hit) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (end_hit) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (end_hit) begin
            tick_cnt <= '0;
            par_bit  <= rx_s;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (end_hit) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (!rx_s)
              framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad)
              parity_error <= 1'b1;
`endif
            // A same-cycle ack frees the holding register, so the new byte loads without overrun.
            if (frame_ok) begin
              if (!data_valid || data_ack) begin
                data       <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun_error <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
